// File: rtl/rns_mac_sequencer.sv
// Streaming RNS dot-product engine: per-lane modular multiply, then modular accumulate,
// with a valid/ready operand input and a held result output.
module rns_mac_sequencer #(
    parameter int unsigned B0    = 251,
    parameter int unsigned B1    = 241,
    parameter int unsigned B2    = 239,
    parameter int unsigned B3    = 233,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [15:0] MODS [4] = '{16'(B0), 16'(B1), 16'(B2), 16'(B3)};

    state_t           state;
    logic [31:0]      prod;
    logic             prod_valid;
    logic [31:0]      acc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_inc;
    logic             take;

    // The 16-bit product holds any pair of 8-bit residues, so out-of-range inputs reduce correctly.
    function automatic logic [7:0] mul_mod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [15:0] m);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        return 8'(p % m);
    endfunction

    function automatic logic [7:0] add_mod(input logic [7:0] x, input logic [7:0] y,
                                           input logic [8:0] m);
        logic [8:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= m) begin
            s = s - m;
        end
        return 8'(s);
    endfunction

    assign take      = in_valid && in_ready;
    assign count_inc = (count == '1) ? count : count + CNT_W'(1);
    assign out_acc   = acc;
    assign out_count = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            prod       <= '0;
            prod_valid <= 1'b0;
            acc        <= '0;
            count      <= '0;
        end else begin
            prod_valid <= take;
            if (take) begin
                for (int i = 0; i < 4; i++) begin
                    prod[i*8 +: 8] <= mul_mod(in_a[i*8 +: 8], in_b[i*8 +: 8], MODS[i]);
                end
                count <= count_inc;
            end
            if (prod_valid) begin
                for (int i = 0; i < 4; i++) begin
                    acc[i*8 +: 8] <= add_mod(acc[i*8 +: 8], prod[i*8 +: 8], MODS[i][8:0]);
                end
            end

            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                    if (take) begin
                        busy <= 1'b1;
                        if (in_last) begin
                            state    <= DRAIN;
                            in_ready <= 1'b0;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (take && in_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                // The last product is folded into acc on this same edge, so DONE sees the final sum.
                DRAIN: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        acc       <= '0;
                        count     <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rns_mac_sequencer.sv
// Self-checking bench for rns_mac_sequencer; a second instance with a 2-bit counter
// shares the stimulus to exercise count saturation.
module tb_rns_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;

    logic        in_ready, out_valid, busy;
    logic [31:0] out_acc;
    logic [15:0] out_count;
    logic        in_ready_s, out_valid_s, busy_s;
    logic [31:0] out_acc_s;
    logic [1:0]  out_count_s;

    rns_mac_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
        .out_ready(out_ready), .out_acc(out_acc), .out_count(out_count), .busy(busy)
    );

    rns_mac_sequencer #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid_s),
        .out_ready(out_ready), .out_acc(out_acc_s), .out_count(out_count_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passes = 0;
    logic [31:0] va [$];
    logic [31:0] vb [$];
    localparam int MODS [4] = '{251, 241, 239, 233};

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer dot product per lane, reduced once at the end.
    function automatic logic [31:0] ref_acc();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            int s;
            s = 0;
            for (int k = 0; k < va.size(); k++) begin
                s += int'(va[k][i*8 +: 8]) * int'(vb[k][i*8 +: 8]);
            end
            r[i*8 +: 8] = 8'(s % MODS[i]);
        end
        return r;
    endfunction

    task automatic applyStimulus(input string name, input int hold, input bit gaps);
        int n;
        int t_first;
        int t_last;
        int w;
        logic [31:0] exp_acc;
        n       = va.size();
        t_first = 0;
        t_last  = 0;
        exp_acc = ref_acc();
        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_a     = va[k];
            in_b     = vb[k];
            in_last  = (k == n - 1);
            w = 0;
            while (!in_ready && w < 50) begin
                @(posedge clk);
                #1;
                w++;
            end
            if (!in_ready) begin
                checkOutput({name, "/ready_timeout"}, 32'(in_ready), 32'd1);
                break;
            end
            if (k == 0) t_first = cyc;
            t_last = cyc;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!gaps) checkOutput({name, "/throughput"}, 32'(t_last - t_first), 32'(n - 1));

        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        checkOutput({name, "/latency"}, 32'(cyc), 32'(t_last + 2));
        checkOutput({name, "/out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({name, "/acc"}, out_acc, exp_acc);
        checkOutput({name, "/count"}, 32'(out_count), 32'(n));
        checkOutput({name, "/count_sat"}, 32'(out_count_s), 32'((n > 3) ? 3 : n));
        checkOutput({name, "/in_ready_done"}, 32'(in_ready), 32'd0);
        checkOutput({name, "/busy_done"}, 32'(busy), 32'd1);

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_last  = 1'($urandom);
            in_a     = $urandom;
            in_b     = $urandom;
            @(posedge clk);
            #1;
            checkOutput({name, "/hold_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, "/hold_acc"}, out_acc, exp_acc);
            checkOutput({name, "/hold_count"}, 32'(out_count), 32'(n));
            checkOutput({name, "/hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({name, "/rel_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "/rel_acc"}, out_acc, 32'd0);
        checkOutput({name, "/rel_count"}, 32'(out_count), 32'd0);
        checkOutput({name, "/rel_ready"}, 32'(in_ready), 32'd1);
        checkOutput({name, "/rel_busy"}, 32'(busy), 32'd0);
        va.delete();
        vb.delete();
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "/in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({name, "/out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "/out_acc"}, out_acc, 32'd0);
        checkOutput({name, "/out_count"}, 32'(out_count), 32'd0);
        checkOutput({name, "/busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkReset("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_ready", 32'(in_ready), 32'd1);

        va = '{32'h03030303, 32'h04040404};
        vb = '{32'h05050505, 32'h06060606};
        applyStimulus("basic", 0, 1'b0);

        va = '{32'hE8EEF0FA};
        vb = '{32'hE8EEF0FA};
        applyStimulus("lane_wrap", 0, 1'b0);

        va = '{32'h000000C8, 32'h000000C8, 32'h000000C8};
        vb = '{32'h000000C8, 32'h000000C8, 32'h000000C8};
        applyStimulus("acc_wrap", 0, 1'b0);

        va = '{$urandom, $urandom, $urandom};
        vb = '{$urandom, $urandom, $urandom};
        applyStimulus("backpressure", 5, 1'b0);
        va = '{$urandom, $urandom};
        vb = '{$urandom, $urandom};
        applyStimulus("after_bp", 0, 1'b0);

        in_valid = 1'b1;
        in_last  = 1'b0;
        in_a     = $urandom;
        in_b     = $urandom;
        @(posedge clk);
        #1;
        in_a = $urandom;
        in_b = $urandom;
        @(posedge clk);
        #1;
        checkOutput("midvec_busy", 32'(busy), 32'd1);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkReset("midvec_reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        va = '{32'h02020202};
        vb = '{32'h02020202};
        applyStimulus("post_reset", 0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            va.push_back($urandom);
            vb.push_back($urandom);
        end
        applyStimulus("throughput4", 0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            va.push_back($urandom);
            vb.push_back($urandom);
        end
        applyStimulus("saturate5", 0, 1'b0);

        for (int v = 0; v < 20; v++) begin
            int len;
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) begin
                va.push_back($urandom);
                vb.push_back($urandom);
            end
            applyStimulus($sformatf("rand%0d", v), $urandom_range(0, 3), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
